// File: rtl/serial_word_loader.sv
// Serial-to-parallel word loader: assembles DATA_WIDTH serial bits into a word
// and presents it downstream with a valid/ready handshake and a sticky overrun flag.
module serial_word_loader #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  SIN,
    input  logic                  SIN_VALID,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  DATA_VALID,
    input  logic                  DATA_READY,
    output logic                  BUSY,
    output logic                  OVERRUN,
    input  logic                  CLEAR_OVERRUN
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next, shifted, data_next;
    logic [CW-1:0]         cnt, cnt_next;
    logic                  valid_next, overrun_next;

    // Shift register with the current SIN inserted in the configured bit order.
    always_comb begin
        shifted = shift_reg;
        if (MSB_FIRST) begin
            for (int i = DATA_WIDTH - 1; i > 0; i--) shifted[i] = shift_reg[i-1];
            shifted[0] = SIN;
        end else begin
            for (int i = 0; i < DATA_WIDTH - 1; i++) shifted[i] = shift_reg[i+1];
            shifted[DATA_WIDTH-1] = SIN;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        cnt_next     = cnt;
        data_next    = DATA_OUT;
        valid_next   = DATA_VALID;
        overrun_next = CLEAR_OVERRUN ? 1'b0 : OVERRUN;

        case (state)
            IDLE: begin
                if (START) begin
                    state_next = SHIFT;
                    cnt_next   = '0;
                    shift_next = '0;
                end
            end
            SHIFT: begin
                if (START) begin
                    cnt_next   = '0;
                    shift_next = '0;
                end else if (SIN_VALID) begin
                    shift_next = shifted;
                    if (cnt == LAST_BIT) begin
                        data_next  = shifted;
                        valid_next = 1'b1;
                        cnt_next   = '0;
                        state_next = HOLD;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (DATA_READY) begin
                    valid_next = 1'b0;
                    if (START) begin
                        state_next = SHIFT;
                        cnt_next   = '0;
                        shift_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (START) begin
                    // A set on the same cycle as a clear wins.
                    overrun_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            shift_reg  <= '0;
            cnt        <= '0;
            DATA_OUT   <= '0;
            DATA_VALID <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            state      <= state_next;
            shift_reg  <= shift_next;
            cnt        <= cnt_next;
            DATA_OUT   <= data_next;
            DATA_VALID <= valid_next;
            OVERRUN    <= overrun_next;
        end
    end

    assign BUSY = (state == SHIFT);

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed testbench for serial_word_loader: MSB-first and LSB-first instances
// share one stimulus stream and are checked against hand-computed words.
module tb_serial_word_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       sin;
    logic       sin_valid;
    logic       data_ready;
    logic       clear_overrun;
    logic [7:0] data_out, data_out_lsb;
    logic       data_valid, busy, overrun;
    logic       data_valid_lsb, busy_lsb, overrun_lsb;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_word_loader #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .CLK(clk), .RST(rst), .START(start), .SIN(sin), .SIN_VALID(sin_valid),
        .DATA_OUT(data_out), .DATA_VALID(data_valid), .DATA_READY(data_ready),
        .BUSY(busy), .OVERRUN(overrun), .CLEAR_OVERRUN(clear_overrun)
    );

    serial_word_loader #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .CLK(clk), .RST(rst), .START(start), .SIN(sin), .SIN_VALID(sin_valid),
        .DATA_OUT(data_out_lsb), .DATA_VALID(data_valid_lsb), .DATA_READY(data_ready),
        .BUSY(busy_lsb), .OVERRUN(overrun_lsb), .CLEAR_OVERRUN(clear_overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sin_valid = 1'b1;
        sin       = b;
        tick();
        sin_valid = 1'b0;
        sin       = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Sends w[7] first; checks that no word is presented before the last bit.
    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            send_bit(w[i]);
            if (i > 0) begin
                check("busy_mid_frame", 32'(busy), 32'd1);
                check("valid_mid_frame", 32'(data_valid), 32'd0);
            end
        end
    endtask

    task automatic accept();
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gaps[8] = '{2, 1, 3, 0, 2, 1, 2, 1};
        logic [7:0] gap_word = 8'h96;

        rst = 1'b1; start = 1'b0; sin = 1'b0; sin_valid = 1'b0;
        data_ready = 1'b0; clear_overrun = 1'b0;
        #1;
        check("reset_data_out", 32'(data_out), 32'h00);
        check("reset_valid", 32'(data_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // IDLE ignores SIN_VALID, and READY without a pending word does nothing.
        send_bit(1'b1);
        data_ready = 1'b1;
        send_bit(1'b1);
        data_ready = 1'b0;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_valid", 32'(data_valid), 32'd0);

        // Basic frame 0xA5.
        pulse_start();
        check("start_busy", 32'(busy), 32'd1);
        check("start_valid", 32'(data_valid), 32'd0);
        send_word(8'hA5);
        check("a5_data", 32'(data_out), 32'hA5);
        check("a5_valid", 32'(data_valid), 32'd1);
        check("a5_busy", 32'(busy), 32'd0);
        check("a5_lsb_data", 32'(data_out_lsb), 32'hA5);
        accept();
        check("a5_accept_valid", 32'(data_valid), 32'd0);
        check("a5_accept_busy", 32'(busy), 32'd0);
        check("a5_accept_data", 32'(data_out), 32'hA5);

        // Stream 1,1,0,0,0,0,0,0 with SIN_VALID on the START cycle (not sampled).
        start = 1'b1; sin_valid = 1'b1; sin = 1'b1;
        tick();
        start = 1'b0; sin_valid = 1'b0; sin = 1'b0;
        send_word(8'hC0);
        check("c0_msb_data", 32'(data_out), 32'hC0);
        check("c0_lsb_data", 32'(data_out_lsb), 32'h03);
        check("c0_lsb_valid", 32'(data_valid_lsb), 32'd1);
        accept();

        // Gapped SIN_VALID: 8 bits over 20 cycles.
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            repeat (gaps[i]) begin
                tick();
                check("gap_busy", 32'(busy), 32'd1);
                check("gap_valid", 32'(data_valid), 32'd0);
            end
            send_bit(gap_word[7-i]);
            if (i < 7) check("gap_bit_valid", 32'(data_valid), 32'd0);
        end
        check("gap_data", 32'(data_out), 32'h96);
        check("gap_valid_end", 32'(data_valid), 32'd1);
        check("gap_lsb_data", 32'(data_out_lsb), 32'h69);
        accept();

        // Abort: five bits, START again (beats SIN_VALID), then 0x3C.
        pulse_start();
        repeat (5) send_bit(1'b1);
        start = 1'b1; sin_valid = 1'b1; sin = 1'b1;
        tick();
        start = 1'b0; sin_valid = 1'b0; sin = 1'b0;
        check("abort_busy", 32'(busy), 32'd1);
        check("abort_valid", 32'(data_valid), 32'd0);
        check("abort_data_kept", 32'(data_out), 32'h96);
        send_word(8'h3C);
        check("abort_data", 32'(data_out), 32'h3C);
        check("abort_valid_end", 32'(data_valid), 32'd1);
        accept();

        // Overrun on START while a word is pending.
        pulse_start();
        send_word(8'h11);
        check("ovr_word", 32'(data_out), 32'h11);
        pulse_start();
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_data_held", 32'(data_out), 32'h11);
        check("ovr_still_valid", 32'(data_valid), 32'd1);
        check("ovr_not_busy", 32'(busy), 32'd0);
        tick();
        check("ovr_sticky", 32'(overrun), 32'd1);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'd0);
        start = 1'b1; clear_overrun = 1'b1;
        tick();
        start = 1'b0; clear_overrun = 1'b0;
        check("ovr_set_wins", 32'(overrun), 32'd1);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;

        // Back-to-back: READY and START together in HOLD.
        data_ready = 1'b1; start = 1'b1;
        tick();
        data_ready = 1'b0; start = 1'b0;
        check("b2b_valid_drop", 32'(data_valid), 32'd0);
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_data_held", 32'(data_out), 32'h11);
        send_word(8'hFF);
        check("b2b_data", 32'(data_out), 32'hFF);
        check("b2b_valid", 32'(data_valid), 32'd1);

        // Leave OVERRUN set, return to IDLE, then reset mid-frame.
        pulse_start();
        accept();
        check("pre_rst_overrun", 32'(overrun), 32'd1);
        pulse_start();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        #3 rst = 1'b1;
        #1;
        check("rst_async_data", 32'(data_out), 32'h00);
        check("rst_async_busy", 32'(busy), 32'd0);
        check("rst_async_valid", 32'(data_valid), 32'd0);
        check("rst_async_overrun", 32'(overrun), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        pulse_start();
        send_word(8'h5A);
        check("post_rst_data", 32'(data_out), 32'h5A);
        check("post_rst_valid", 32'(data_valid), 32'd1);
        check("post_rst_lsb_data", 32'(data_out_lsb), 32'h5A);
        accept();
        check("post_rst_accept", 32'(data_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
